// File: rtl/calc_pkg.sv
// Shared types and constants for the UART calculator core: FSM and transmit
// phase encodings, command codes and byte-lane / status helpers.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_OP2  = 3'd2,
    ST_CMD  = 3'd3,
    ST_EXEC = 3'd4,
    ST_TX   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TXP_LOAD    = 2'd0,
    TXP_WAIT_HI = 2'd1,
    TXP_WAIT_LO = 2'd2
  } tx_phase_t;

  localparam logic [7:0] CMD_ADD = 8'h00;
  localparam logic [7:0] CMD_SUB = 8'h01;
  localparam logic [7:0] CMD_AND = 8'h02;
  localparam logic [7:0] CMD_OR  = 8'h03;
  localparam logic [7:0] CMD_XOR = 8'h04;
  localparam logic [7:0] CMD_SHL = 8'h05;
  localparam logic [7:0] CMD_MAX = 8'h05;

  // Maps the n-th byte on the wire to its byte lane inside a multi-byte word
  function automatic int unsigned byte_lane(input int unsigned idx,
                                            input int unsigned n_bytes,
                                            input bit          lsb_first);
    if (lsb_first) begin
      return idx;
    end else begin
      return n_bytes - 32'd1 - idx;
    end
  endfunction

  function automatic logic [7:0] status_byte(input logic zero, input logic carry);
    return {6'b000000, zero, carry};
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for the calculator core: six operations on W-bit operands
// producing a result plus carry/borrow and zero flags.
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] op1_i,
  input  logic [W-1:0] op2_i,
  input  logic [7:0]   cmd_i,
  output logic [W-1:0] result_o,
  output logic         carry_o,
  output logic         zero_o
);

  localparam int SW = $clog2(W);

  logic [W:0]     sum_s;
  logic [W:0]     diff_s;
  logic [SW-1:0]  amt_s;
  logic [2*W-1:0] shl_s;

  assign sum_s  = {1'b0, op1_i} + {1'b0, op2_i};
  assign diff_s = {1'b0, op1_i} - {1'b0, op2_i};
  assign amt_s  = op2_i[SW-1:0];
  // Bit W of the widened shift is the last bit pushed out (0 for a zero shift)
  assign shl_s  = {{W{1'b0}}, op1_i} << amt_s;

  // Operation select
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (cmd_i)
      CMD_ADD: begin
        result_o = sum_s[W-1:0];
        carry_o  = sum_s[W];
      end
      CMD_SUB: begin
        result_o = diff_s[W-1:0];
        carry_o  = diff_s[W];
      end
      CMD_AND: result_o = op1_i & op2_i;
      CMD_OR:  result_o = op1_i | op2_i;
      CMD_XOR: result_o = op1_i ^ op2_i;
      CMD_SHL: begin
        result_o = shl_s[W-1:0];
        carry_o  = shl_s[W];
      end
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/uart_calc_engine.sv
// Calculator core: assembles two operands and a command from a UART byte
// stream, executes one ALU operation and returns result and status bytes.
module uart_calc_engine
  import calc_pkg::*;
#(
  parameter int N_BYTES        = 2,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 100000000,
  localparam int W             = 8 * N_BYTES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_ready,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic [W-1:0] op1,
  output logic [W-1:0] op2,
  output logic [W-1:0] result,
  output logic [2:0]   state_id,
  output logic         result_valid,
  output logic         flag_carry,
  output logic         flag_zero,
  output logic         err_cmd,
  output logic         err_timeout
);

  localparam int CW = $clog2(N_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX   = CW'(N_BYTES - 1);
  localparam logic [CW-1:0] STATUS_IDX = CW'(N_BYTES);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q;
  tx_phase_t     tx_phase_q;
  logic [CW-1:0] byte_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    cmd_q;
  logic [W-1:0]  op1_q;
  logic [W-1:0]  op2_q;
  logic [W-1:0]  result_q;
  logic          carry_q;
  logic          zero_q;
  logic          result_valid_q;
  logic          err_cmd_q;
  logic          err_timeout_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;

  logic [W-1:0]  op1_d;
  logic [W-1:0]  op2_d;
  logic [W-1:0]  result_d;
  logic          carry_d;
  logic          zero_d;
  logic [7:0]    tx_byte_d;
  logic [W-1:0]  result_shift_s;
  logic          open_s;
  logic          expired_s;
  int unsigned   lane_s;

  function automatic logic [W-1:0] put_byte(input logic [W-1:0] base,
                                            input int unsigned  lane,
                                            input logic [7:0]   b);
    logic [W-1:0] mask;
    mask = W'(8'hFF) << (32'd8 * lane);
    return (base & ~mask) | (W'(b) << (32'd8 * lane));
  endfunction

  assign lane_s    = byte_lane(32'(byte_cnt_q), N_BYTES, LSB_FIRST);
  assign open_s    = (state_q == ST_OP1) || (state_q == ST_OP2) || (state_q == ST_CMD);
  // A byte arriving on the expiry cycle keeps the frame alive
  assign expired_s = open_s && !rx_ready && (to_cnt_q == TO_LAST);

  // First byte of each operand starts from a cleared register
  assign op1_d = put_byte((state_q == ST_IDLE) ? '0 : op1_q, lane_s, rx_data);
  assign op2_d = put_byte((byte_cnt_q == '0) ? '0 : op2_q, lane_s, rx_data);

  assign result_shift_s = result_q >> (32'd8 * lane_s);

  // Next byte to hand to the UART: result lanes, then the status byte
  always_comb begin
    tx_byte_d = 8'h00;
    if (byte_cnt_q == STATUS_IDX) begin
      tx_byte_d = status_byte(zero_q, carry_q);
    end else begin
      tx_byte_d = result_shift_s[7:0];
    end
  end

  calc_alu #(.W(W)) u_alu (
    .op1_i    (op1_q),
    .op2_i    (op2_q),
    .cmd_i    (cmd_q),
    .result_o (result_d),
    .carry_o  (carry_d),
    .zero_o   (zero_d)
  );

  // Frame assembly, execution, transmit sequencing and inter-byte timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      tx_phase_q     <= TXP_LOAD;
      byte_cnt_q     <= '0;
      to_cnt_q       <= '0;
      cmd_q          <= 8'h00;
      op1_q          <= '0;
      op2_q          <= '0;
      result_q       <= '0;
      carry_q        <= 1'b0;
      zero_q         <= 1'b0;
      result_valid_q <= 1'b0;
      err_cmd_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
    end else begin
      result_valid_q <= 1'b0;
      err_cmd_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      tx_start_q     <= 1'b0;

      if (rx_ready || !open_s || expired_s) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      if (expired_s) begin
        err_timeout_q <= 1'b1;
        state_q       <= ST_IDLE;
        byte_cnt_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_ready) begin
              op1_q <= op1_d;
              if (N_BYTES == 1) begin
                state_q    <= ST_OP2;
                byte_cnt_q <= '0;
              end else begin
                state_q    <= ST_OP1;
                byte_cnt_q <= CW'(1);
              end
            end
          end
          ST_OP1: begin
            if (rx_ready) begin
              op1_q <= op1_d;
              if (byte_cnt_q == LAST_IDX) begin
                state_q    <= ST_OP2;
                byte_cnt_q <= '0;
              end else begin
                byte_cnt_q <= byte_cnt_q + CW'(1);
              end
            end
          end
          ST_OP2: begin
            if (rx_ready) begin
              op2_q <= op2_d;
              if (byte_cnt_q == LAST_IDX) begin
                state_q    <= ST_CMD;
                byte_cnt_q <= '0;
              end else begin
                byte_cnt_q <= byte_cnt_q + CW'(1);
              end
            end
          end
          ST_CMD: begin
            if (rx_ready) begin
              if (rx_data > CMD_MAX) begin
                err_cmd_q <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                cmd_q   <= rx_data;
                state_q <= ST_EXEC;
              end
            end
          end
          ST_EXEC: begin
            result_q       <= result_d;
            carry_q        <= carry_d;
            zero_q         <= zero_d;
            result_valid_q <= 1'b1;
            state_q        <= ST_TX;
            byte_cnt_q     <= '0;
            tx_phase_q     <= TXP_LOAD;
          end
          ST_TX: begin
            case (tx_phase_q)
              TXP_LOAD: begin
                if (!tx_busy) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= tx_byte_d;
                  tx_phase_q <= TXP_WAIT_HI;
                end
              end
              TXP_WAIT_HI: begin
                if (tx_busy) begin
                  tx_phase_q <= TXP_WAIT_LO;
                end
              end
              TXP_WAIT_LO: begin
                if (!tx_busy) begin
                  tx_phase_q <= TXP_LOAD;
                  if (byte_cnt_q == STATUS_IDX) begin
                    state_q    <= ST_IDLE;
                    byte_cnt_q <= '0;
                  end else begin
                    byte_cnt_q <= byte_cnt_q + CW'(1);
                  end
                end
              end
              default: tx_phase_q <= TXP_LOAD;
            endcase
          end
          default: begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign result       = result_q;
  assign state_id     = state_q;
  assign result_valid = result_valid_q;
  assign flag_carry   = carry_q;
  assign flag_zero    = zero_q;
  assign err_cmd      = err_cmd_q;
  assign err_timeout  = err_timeout_q;

endmodule
